// File: rtl/sam_tok_pkg.sv
// sam_tok_pkg: stream token encoding and helpers shared by sparse-stream blocks
package sam_tok_pkg;
  localparam int DATA_W = 17;
  typedef logic [DATA_W-1:0] tok_t;
  localparam tok_t TOK_DONE = 17'h10100;
  localparam tok_t TOK_R = 17'h00001;
  typedef enum logic [1:0] {START, PASS, DONE} rsg_state_e;
  function automatic logic is_ctrl(tok_t t);
    return t[16];
  endfunction
  function automatic logic is_stop(tok_t t);
    return t[16] && t[15:8] == 8'h00;
  endfunction
  function automatic logic is_done(tok_t t);
    return t == TOK_DONE;
  endfunction
endpackage

// File: rtl/reg_fifo.sv
// reg_fifo: register-based FIFO with registered output, flush and clock enable
module reg_fifo #(
  parameter int DATA_W = 17,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clk_en) begin
      if (flush) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (do_push) begin
          mem[wp] <= din;
          wp <= wp + AW'(1);
        end
        if (do_pop) rp <= rp + AW'(1);
        cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
    end
  end
endmodule

// File: rtl/rep_sig_gen.sv
// rep_sig_gen: maps coordinate tokens to repeat tokens, passing stop/done through
module rep_sig_gen
  import sam_tok_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic [DATA_W-1:0] base_data_in,
  input  logic              base_data_in_valid,
  output logic              base_data_in_ready,
  output logic [DATA_W-1:0] repsig_data_out,
  output logic              repsig_data_out_valid,
  input  logic              repsig_data_out_ready,
  output logic [15:0]       rep_count
);
  rsg_state_e state;
  tok_t in_dout, out_dout, out_din;
  logic in_full, in_empty, out_full, out_empty;
  logic alive, run, xfer;
  assign run = clk_en && tile_en;
  // alive keeps ready low while reset is held and until the first clock after release
  assign base_data_in_ready = alive && run && !in_full;
  assign repsig_data_out_valid = run && !out_empty;
  assign repsig_data_out = repsig_data_out_valid ? out_dout : '0;
  assign xfer = run && state == PASS && !in_empty && !out_full;
  assign out_din = is_ctrl(in_dout) ? in_dout : TOK_R;
  reg_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .push(base_data_in_valid && base_data_in_ready), .pop(xfer),
    .din(base_data_in), .dout(in_dout), .full(in_full), .empty(in_empty)
  );
  reg_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush),
    .push(xfer), .pop(repsig_data_out_valid && repsig_data_out_ready),
    .din(out_din), .dout(out_dout), .full(out_full), .empty(out_empty)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= START;
      rep_count <= '0;
      alive <= 1'b0;
    end else if (clk_en) begin
      alive <= 1'b1;
      if (flush) begin
        state <= START;
        rep_count <= '0;
      end else if (tile_en) begin
        unique case (state)
          START: if (!in_empty) state <= PASS;
          PASS: if (xfer) begin
            if (!is_ctrl(in_dout) && rep_count != 16'hFFFF) rep_count <= rep_count + 16'd1;
            if (is_done(in_dout)) state <= DONE;
          end
          DONE: begin
            rep_count <= '0;
            state <= START;
          end
          default: state <= START;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rep_sig_gen.sv
// tb_rep_sig_gen: scoreboard bench for rep_sig_gen stream mapping, backpressure and reset
module tb_rep_sig_gen;
  logic clk = 1'b0;
  logic rst_n, clk_en, flush, tile_en;
  logic [16:0] base_data_in;
  logic base_data_in_valid, base_data_in_ready;
  logic [16:0] repsig_data_out;
  logic repsig_data_out_valid, repsig_data_out_ready;
  logic [15:0] rep_count;
  logic [16:0] exp_q [$];
  int checks = 0;
  int passes = 0;
  bit toggle_rdy = 1'b0;

  rep_sig_gen dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .base_data_in(base_data_in), .base_data_in_valid(base_data_in_valid),
    .base_data_in_ready(base_data_in_ready), .repsig_data_out(repsig_data_out),
    .repsig_data_out_valid(repsig_data_out_valid),
    .repsig_data_out_ready(repsig_data_out_ready), .rep_count(rep_count)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] map_tok(logic [16:0] t);
    return t[16] ? t : 17'h00001;
  endfunction

  always @(negedge clk) begin
    if (rst_n && repsig_data_out_valid && repsig_data_out_ready) begin
      checks++;
      if (exp_q.size() == 0) $display("FAIL out_unexpected got=%h required=none", repsig_data_out);
      else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if (repsig_data_out !== e) $display("FAIL out_token got=%h required=%h", repsig_data_out, e);
        else passes++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle_rdy) repsig_data_out_ready = ~repsig_data_out_ready;
  endtask

  task automatic send(input logic [16:0] tok);
    bit acc = 1'b0;
    base_data_in = tok;
    base_data_in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = base_data_in_ready;
      if (acc) exp_q.push_back(map_tok(tok));
      tick();
    end
    base_data_in_valid = 1'b0;
    if (!acc) begin
      checks++;
      $display("FAIL send_timeout tok=%h got=not_accepted required=accepted", tok);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    tick();
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drain got=%0d_pending required=0", name, exp_q.size());
    else passes++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) $display("FAIL %s got=%h required=%h", name, got, req);
    else passes++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; tile_en = 1'b1;
    base_data_in = '0; base_data_in_valid = 1'b0; repsig_data_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (base_data_in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b required=0", base_data_in_ready); else passes++;
    checks++; if (repsig_data_out_valid !== 1'b0) $display("FAIL rst_valid got=%b required=0", repsig_data_out_valid); else passes++;
    checks++; if (repsig_data_out !== 17'h0) $display("FAIL rst_data got=%h required=0", repsig_data_out); else passes++;
    checks++; if (rep_count !== 16'h0) $display("FAIL rst_count got=%h required=0", rep_count); else passes++;
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (base_data_in_ready !== 1'b1) $display("FAIL post_rst_ready got=%b required=1", base_data_in_ready); else passes++;
    tick();
  endtask

  task automatic test_basic();
    send(17'h00000); send(17'h00001); send(17'h00002); send(17'h10000);
    drain("basic_a");
    checks++; if (rep_count !== 16'd3) $display("FAIL basic_count_pre got=%0d required=3", rep_count); else passes++;
    send(17'h10100);
    drain("basic_b");
    checks++; if (rep_count !== 16'd0) $display("FAIL basic_count_post got=%0d required=0", rep_count); else passes++;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    toggle_rdy = 1'b1;
    send(17'h00000); send(17'h00001); send(17'h00002); send(17'h10000); send(17'h10100);
    drain("toggle");
    toggle_rdy = 1'b0;
    repsig_data_out_ready = 1'b0;
    base_data_in = 17'h00004;
    base_data_in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (base_data_in_ready) begin
        acc++;
        exp_q.push_back(17'h00001);
      end
      tick();
    end
    @(negedge clk);
    checks++; if (acc !== 4) $display("FAIL stall_accepted got=%0d required=4", acc); else passes++;
    checks++; if (base_data_in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b required=0", base_data_in_ready); else passes++;
    base_data_in_valid = 1'b0;
    tick();
    repsig_data_out_ready = 1'b1;
    send(17'h10100);
    drain("stall");
  endtask

  task automatic test_nested();
    send(17'h00005); send(17'h10000); send(17'h00007); send(17'h00008); send(17'h10001); send(17'h10100);
    drain("nested");
    checks++; if (rep_count !== 16'd0) $display("FAIL nested_count got=%0d required=0", rep_count); else passes++;
  endtask

  task automatic test_back_to_back();
    send(17'h00003); send(17'h10000); send(17'h10100);
    send(17'h00004); send(17'h00006); send(17'h10000); send(17'h10100);
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    repsig_data_out_ready = 1'b0;
    send(17'h00001); send(17'h00002);
    tick(); tick();
    @(negedge clk);
    checks++; if (rep_count !== 16'd2) $display("FAIL mid_count_pre got=%0d required=2", rep_count); else passes++;
    checks++; if (repsig_data_out_valid !== 1'b1) $display("FAIL mid_valid_pre got=%b required=1", repsig_data_out_valid); else passes++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (repsig_data_out_valid !== 1'b0) $display("FAIL mid_valid_rst got=%b required=0", repsig_data_out_valid); else passes++;
    checks++; if (rep_count !== 16'd0) $display("FAIL mid_count_rst got=%0d required=0", rep_count); else passes++;
    exp_q.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    repsig_data_out_ready = 1'b1;
    send(17'h00009); send(17'h10100);
    drain("mid");
  endtask

  task automatic test_tile_en();
    int acc = 0;
    int vld = 0;
    send(17'h00001); send(17'h00002);
    drain("tile_a");
    checks++; if (rep_count !== 16'd2) $display("FAIL tile_count_pre got=%0d required=2", rep_count); else passes++;
    tile_en = 1'b0;
    base_data_in = 17'h00003;
    base_data_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (base_data_in_ready) acc++;
      if (repsig_data_out_valid) vld++;
      tick();
    end
    base_data_in_valid = 1'b0;
    checks++; if (acc !== 0) $display("FAIL tile_accepts got=%0d required=0", acc); else passes++;
    checks++; if (vld !== 0) $display("FAIL tile_valids got=%0d required=0", vld); else passes++;
    checks++; if (rep_count !== 16'd2) $display("FAIL tile_count_hold got=%0d required=2", rep_count); else passes++;
    tile_en = 1'b1;
    send(17'h00003); send(17'h10000); send(17'h10100);
    drain("tile_b");
    checks++; if (rep_count !== 16'd0) $display("FAIL tile_count_post got=%0d required=0", rep_count); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_nested();
    test_back_to_back();
    test_reset_mid();
    test_tile_en();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1);
  end
endmodule
